// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one fixed-latency WIDTHxWIDTH multiplier among N_REQ requesters,
// with an ID tag pipeline and a credit-protected response FIFO. Define MULT_SHARE_PRIO0_EN for strict requester-0 priority.
module mult_share_arb #(
    parameter int  N_REQ      = 4,
    parameter int  WIDTH      = 24,
    parameter int  MUL_LAT    = 2,
    parameter int  FIFO_DEPTH = 4,
    localparam int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_valid,
    input  logic [2*WIDTH-1:0]       mul_p,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [2*WIDTH-1:0]       rsp_p,
    output logic                     busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;
    localparam int EW = IDW + 2 * WIDTH;

    logic [IDW-1:0]              last, gnt_id, idx, issue_id;
    logic                        gnt_found, credit_ok, xfer, push, pop;
    logic [CW-1:0]               fifo_count, inflight;
    logic [MUL_LAT-1:0]          vld_pipe;
    logic [MUL_LAT-1:0][IDW-1:0] id_pipe;
    logic [PW-1:0]               wr_ptr, rd_ptr, rd_nxt;
    logic [EW-1:0]               mem [FIFO_DEPTH];
    logic [EW-1:0]               wdata;

    // Credit counts everything already committed downstream, so the FIFO can never overflow.
    assign credit_ok = (fifo_count + inflight) < CW'(FIFO_DEPTH);

    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = '0;
`ifdef MULT_SHARE_PRIO0_EN
        if (req_valid[0]) begin
            gnt_found = 1'b1;
        end else begin
            for (int k = 1; k < N_REQ; k++) begin
                idx = IDW'(1 + ((int'(last) - 1 + k) % (N_REQ - 1)));
                if (!gnt_found && req_valid[idx]) begin
                    gnt_found = 1'b1;
                    gnt_id    = idx;
                end
            end
        end
`else
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDW'((int'(last) + k) % N_REQ);
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = idx;
            end
        end
`endif
    end

    assign xfer      = gnt_found & credit_ok;
    assign req_ready = xfer ? (N_REQ'(1) << gnt_id) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_valid <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            issue_id  <= '0;
            last      <= IDW'(N_REQ - 1);
        end else begin
            mul_valid <= xfer;
            if (xfer) begin
                mul_a    <= req_a[gnt_id*WIDTH +: WIDTH];
                mul_b    <= req_b[gnt_id*WIDTH +: WIDTH];
                issue_id <= gnt_id;
`ifdef MULT_SHARE_PRIO0_EN
                if (gnt_id != '0) last <= gnt_id;
`else
                last <= gnt_id;
`endif
            end
        end
    end

    // Tags travel in lockstep with the multiplier; reset drops them so a draining multiplier is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            for (int s = MUL_LAT - 1; s > 0; s--) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
            vld_pipe[0] <= mul_valid;
            id_pipe[0]  <= issue_id;
        end
    end

    assign push      = vld_pipe[MUL_LAT-1];
    assign wdata     = {id_pipe[MUL_LAT-1], mul_p};
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rd_nxt    = rd_ptr + PW'(pop);
    assign busy      = (inflight != '0) | (fifo_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            inflight   <= inflight + CW'(xfer) - CW'(push);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= rd_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Head register looks ahead to the next read slot, bypassing a same-edge write into that slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {rsp_id, rsp_p} <= '0;
        end else if (push && (wr_ptr == rd_nxt)) begin
            {rsp_id, rsp_p} <= wdata;
        end else begin
            {rsp_id, rsp_p} <= mem[rd_nxt];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            assert (!(push && !pop && (fifo_count == CW'(FIFO_DEPTH))))
                else $error("mult_share_arb: output FIFO overflow");
        end
    end
endmodule

// File: tb/tb_mult_share_arb.sv
// Randomized and directed bench for mult_share_arb against a transaction-level queue model.
module tb_mult_share_arb;
    localparam int N   = 4;
    localparam int W   = 24;
    localparam int LAT = 2;
    localparam int DEP = 4;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid, req_ready;
    logic [N*W-1:0]     req_a, req_b;
    logic [W-1:0]       mul_a, mul_b;
    logic               mul_valid;
    logic [2*W-1:0]     mul_p;
    logic               rsp_valid, rsp_ready, busy;
    logic [IDW-1:0]     rsp_id;
    logic [2*W-1:0]     rsp_p;

    mult_share_arb #(.N_REQ(N), .WIDTH(W), .MUL_LAT(LAT), .FIFO_DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
        .mul_valid(mul_valid), .mul_p(mul_p), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
    );

    always #5 clk = ~clk;

    // Environment multiplier: fixed LAT-cycle pipeline.
    logic [2*W-1:0] mp_pipe [LAT];
    always @(posedge clk) begin
        for (int s = LAT - 1; s > 0; s--) mp_pipe[s] <= mp_pipe[s-1];
        mp_pipe[0] <= (2*W)'(mul_a) * (2*W)'(mul_b);
    end
    assign mul_p = mp_pipe[LAT-1];

    typedef struct {
        int             id;
        logic [2*W-1:0] p;
        int             rdy;
    } rsp_t;

    rsp_t           q[$];
    int             last_m, edge_n;
    logic           mv_e;
    logic [W-1:0]   ma_e, mb_e;
    int             checks = 0, errors = 0;
    int             gnt_log[$];
    int             pop_id[$];
    logic [2*W-1:0] pop_p[$];
    logic [N-1:0]   last_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v);
        if (q.size() >= DEP) return -1;
`ifdef MULT_SHARE_PRIO0_EN
        if (v[0]) return 0;
        for (int k = 1; k < N; k++) begin
            int i = 1 + (last_m - 1 + k) % (N - 1);
            if (v[i]) return i;
        end
`else
        for (int k = 1; k <= N; k++) begin
            int i = (last_m + k) % N;
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic logic head_ready();
        return (q.size() > 0) && (q[0].rdy <= edge_n);
    endfunction

    task automatic check_state();
        logic ev;
        ev = head_ready();
        chk("rsp_valid", rsp_valid, ev);
        if (ev) begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_p", rsp_p, q[0].p);
        end
        chk("busy", busy, q.size() != 0);
        chk("mul_valid", mul_valid, mv_e);
        chk("mul_a", mul_a, ma_e);
        chk("mul_b", mul_b, mb_e);
    endtask

    // One clock: drive at negedge, check ready, advance model, then check registered outputs at next negedge.
    task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b, input logic rr);
        int g, gd;
        logic [W-1:0] av, bv;
        req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
        #1;
        g = model_grant(v);
        chk("req_ready", req_ready, (g >= 0) ? (N'(1) << g) : '0);
        last_ready = req_ready;
        gd = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) gd = i;
        gnt_log.push_back(gd);
        if (rsp_valid && rr) begin
            pop_id.push_back(int'(rsp_id));
            pop_p.push_back(rsp_p);
        end
        if (head_ready() && rr) void'(q.pop_front());
        if (g >= 0) begin
            av = a[g*W +: W];
            bv = b[g*W +: W];
            q.push_back('{id: g, p: (2*W)'(av) * (2*W)'(bv), rdy: edge_n + LAT + 2});
`ifdef MULT_SHARE_PRIO0_EN
            if (g != 0) last_m = g;
`else
            last_m = g;
`endif
            mv_e = 1'b1; ma_e = av; mb_e = bv;
        end else begin
            mv_e = 1'b0;
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        check_state();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0; req_valid = '0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_valid", mul_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_rsp_p", rsp_p, 0);
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_rsp_valid", rsp_valid, 0);
        chk("rst_hold_busy", busy, 0);
        q.delete(); last_m = N - 1; mv_e = 1'b0; ma_e = '0; mb_e = '0;
        rst = 1'b1;
    endtask

    task automatic idle(input int n, input logic rr);
        repeat (n) cycle('0, '0, '0, rr);
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() > 0 && k < 50) begin
            cycle('0, '0, '0, 1'b1);
            k++;
        end
        chk("drain_busy", busy, 0);
    endtask

    function automatic logic [N*W-1:0] lane(input int i, input logic [W-1:0] v);
        logic [N*W-1:0] r = '0;
        r[i*W +: W] = v;
        return r;
    endfunction

    initial begin
        logic [N*W-1:0] ra, rb;
        logic [N-1:0]   pend;
        int             cnt;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        edge_n = 0; last_ready = '0;
        #2;
        do_reset(2);

        // Single request from requester 0.
        cycle(4'b0001, lane(0, 24'd1000), lane(0, 24'd2000), 1'b1);
        idle(3, 1'b1);
        chk("single_valid", rsp_valid, 1);
        chk("single_id", rsp_id, 0);
        chk("single_p", rsp_p, 48'd2000000);
        idle(1, 1'b1);
        chk("single_busy_after_pop", busy, 0);

        // All requesters at once from a fresh reset.
        do_reset(1);
        gnt_log.delete(); pop_id.delete(); pop_p.delete();
        ra = '0; rb = '0;
        for (int i = 0; i < N; i++) begin
            ra[i*W +: W] = W'(i + 1);
            rb[i*W +: W] = W'(3);
        end
        pend = '1;
        repeat (4) begin
            cycle(pend, ra, rb, 1'b1);
            pend = pend & ~last_ready;
        end
        drain();
        for (int i = 0; i < 4; i++) begin
            chk("all_grant_order", gnt_log[i], i);
            chk("all_rsp_id", pop_id[i], i);
            chk("all_rsp_p", pop_p[i], 48'(3 * (i + 1)));
        end

        // Backpressure on requester 2.
        gnt_log.delete();
        repeat (8) cycle(4'b0100, lane(2, 24'd77), lane(2, 24'd5), 1'b0);
        cnt = 0;
        foreach (gnt_log[i]) if (gnt_log[i] == 2) cnt++;
        chk("bp_transfers", cnt, 4);
        chk("bp_ready_stalled", last_ready, 0);
        chk("bp_head_id", rsp_id, 2);
        cycle(4'b0100, lane(2, 24'd77), lane(2, 24'd5), 1'b1);
        chk("bp_ready_during_pop", last_ready, 0);
        cycle(4'b0100, lane(2, 24'd77), lane(2, 24'd5), 1'b0);
        chk("bp_ready_after_pop", last_ready, 4'b0100);
        drain();

        // Maximum and zero operands.
        cycle(4'b0001, lane(0, 24'hFFFFFF), lane(0, 24'hFFFFFF), 1'b1);
        cycle(4'b0010, lane(1, 24'h000000), lane(1, 24'hFFFFFF), 1'b1);
        idle(2, 1'b0);
        chk("max_p", rsp_p, 48'hFFFFFE000001);
        idle(1, 1'b1);
        chk("zero_valid", rsp_valid, 1);
        chk("zero_p", rsp_p, 48'h0);
        drain();

        // Randomized traffic with bursty backpressure.
        for (int c = 0; c < 1500; c++) begin
            logic [N-1:0] v;
            logic         rr;
            v = N'($urandom);
            for (int i = 0; i < N; i++) begin
                ra[i*W +: W] = ($urandom_range(0, 7) == 0) ? W'('1) : W'($urandom);
                rb[i*W +: W] = ($urandom_range(0, 7) == 0) ? W'('1) : W'($urandom);
            end
            rr = ((c / 100) % 3 == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle(v, ra, rb, rr);
        end
        drain();

        // Reset mid-operation, then priority/alternation check.
        for (int i = 0; i < N; i++) begin
            ra[i*W +: W] = W'($urandom);
            rb[i*W +: W] = W'($urandom);
        end
        repeat (3) cycle(4'b1111, ra, rb, 1'b1);
        idle(1, 1'b1);
        do_reset(1);
        idle(6, 1'b1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        gnt_log.delete();
        repeat (4) cycle(4'b0011, ra, rb, 1'b1);
`ifdef MULT_SHARE_PRIO0_EN
        for (int i = 0; i < 4; i++) chk("prio_grant", gnt_log[i], 0);
`else
        for (int i = 0; i < 4; i++) chk("rr_grant", gnt_log[i], i % 2);
`endif
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter and sequencer sharing one fixed-latency 24x24 unsigned multiplier (the Karatsuba/Booth product unit) among `N_REQ` requesters in the nonlinear-approximation datapath. Accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle. Tracks requester IDs through the multiplier pipeline and returns tagged 48-bit products through a credit-protected output FIFO with backpressure.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 24: operand width; product is `2*WIDTH`.
- `MUL_LAT`, 2: cycles from `mul_valid` high to the matching `mul_p` valid; 1..8.
- `FIFO_DEPTH`, 4: output FIFO entries, power of two, >= 2.
- `IDW`, derived as clog2(`N_REQ`): ID width.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `N_REQ`  per-requester operand valid.
- `req_ready`  out  `N_REQ`  per-requester grant; one-hot or zero.
- `req_a`, `req_b`  in  `N_REQ*WIDTH`  operands; requester i occupies bits [i*WIDTH +: WIDTH].
- `mul_a`, `mul_b`  out  `WIDTH`  registered operands to the multiplier.
- `mul_valid`  out  1  issue strobe to the multiplier.
- `mul_p`  in  `2*WIDTH`  multiplier product.
- `rsp_valid`  out  1  output FIFO not empty.
- `rsp_ready`  in  1  consumer accepts the head entry.
- `rsp_id`  out  `IDW`  requester ID of the head entry.
- `rsp_p`  out  `2*WIDTH`  product at the head entry.
- `busy`  out  1  any entry in flight or in the FIFO.

## Operation
- **Credit rule.** `credit_ok = (fifo_count + inflight) < FIFO_DEPTH`, computed from registered values only. A pop in the current cycle frees its credit on the next cycle.
- **Arbitration.**
  - When `credit_ok` holds, grant the first requester with `req_valid` set, searching from `last+1` modulo `N_REQ`.
  - Raise `req_ready` for that requester only; the transfer occurs when `req_valid & req_ready`.
  - `last` updates only on a transfer.
  - `req_ready` is combinational from `req_valid`. Requesters must not derive `req_valid` from `req_ready`.
- **Issue stage.** A transfer registers `mul_a`, `mul_b`, `mul_valid=1` and the ID. With no transfer, `mul_valid=0` and the operands hold their previous value.
- **Tag pipeline.** A `MUL_LAT`-deep shift register carries {valid, ID} in lockstep with the multiplier.
- **FIFO write.** When the tag-pipe output is valid, write {ID, `mul_p`} into the FIFO on that edge.
- **Overflow.** The credit rule guarantees the FIFO never overflows. An overflow is a design error; a simulation assertion flags it.
- **In-flight counter.** `inflight` increments on a transfer and decrements on a FIFO write. Both in one cycle leave it unchanged.
- **FIFO pointers.** Pop on `rsp_valid & rsp_ready`. Read and write pointers wrap modulo `FIFO_DEPTH`; a simultaneous push and pop leaves the count unchanged.
- **Output registering.** `rsp_id` and `rsp_p` come from the registered FIFO head (read-data register, not a combinational memory read). They are stable while `rsp_valid & !rsp_ready`.
- **`busy`.** `busy = (inflight != 0) | (fifo_count != 0)`.
- **Reset.**
  - Outputs: `req_ready` (with `req_valid=0`), `mul_valid`, `rsp_valid`, `busy` = 0; `mul_a`, `mul_b`, `rsp_id`, `rsp_p` = 0.
  - State: `last = N_REQ-1`, so requester 0 wins first; counters and pointers = 0.
  - Reset asserted mid-operation discards in-flight tags and FIFO contents. No response emerges after reset release even if the multiplier is still draining.

## Timing
- Transfer at edge t. `mul_valid` is high in cycle t+1. The FIFO write occurs at edge t+1+`MUL_LAT`. With the FIFO empty, `rsp_valid` is high from cycle t+2+`MUL_LAT`.
- Sustained throughput is 1 product/cycle while `rsp_ready=1`, provided `FIFO_DEPTH >= MUL_LAT+2`. Otherwise issue stalls on credit.
- Round-robin fairness: every requester holding `req_valid` is granted within `N_REQ` transfers.

## Configuration
- `MULT_SHARE_PRIO0_EN` defined: requester 0 has strict priority whenever `credit_ok`. Round-robin applies among requesters 1..`N_REQ-1`, and `last` tracks only those.
- Not defined: pure round-robin over all requesters, as described above.

## Test plan
Defaults unless stated; `rsp_ready=1` unless stated.

- **Single request.** Requester 0 sends a=1000, b=2000 at edge t. Required: `rsp_valid` at cycle t+4, `rsp_id=0`, `rsp_p=2000000`, `busy` back to 0 the cycle after the pop.
- **All requesters simultaneously.** Requesters 0..3 hold valid with a=i+1, b=3. Required: grants 0,1,2,3 on consecutive cycles; responses in order with products 3,6,9,12.
- **Backpressure.** `rsp_ready=0`, requester 2 streams requests. Required: exactly 4 transfers; `req_ready` then stays 0. Raising `rsp_ready` for 1 cycle pops ID 2 and permits one new transfer the following cycle.
- **Maximum operands.** a=b=0xFFFFFF. Required: `rsp_p=0xFFFFFE000001`. Also a=0, b=0xFFFFFF gives `rsp_p=0`.
- **Reset mid-operation.** Assert `rst` low 1 cycle after 3 transfers. Required: `rsp_valid`, `busy`, `mul_valid` = 0 during and after release. No stale responses appear. The next grant goes to requester 0.
- **Priority macro.** With `MULT_SHARE_PRIO0_EN`, requesters 0 and 1 both hold valid for 4 cycles. Required: requester 0 receives all 4 grants. Without the macro, grants alternate 0,1,0,1.
